alu_response_tx: RTL and testbench
==================================

# alu_response_tx

Response packetizer on the transmit side of the UART ALU. Accepts one ALU result word plus its opcode via valid/ready, frames it as a response packet (header, little-endian payload, optional checksum), and streams it one byte at a time into the UART transmitter over a byte-wide valid/ready interface. It mirrors the request framing that the receive path and ALU consume: opcode, reserved byte, 16-bit length, operands.

## Interface
- `RESULT_BYTES`, default 4: payload bytes per packet; legal range 1..8.
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high (clock `clk`)
- `opcode_i`  in  8  opcode of the completed operation, echoed in the header
- `result_i`  in  8*RESULT_BYTES  ALU result word
- `result_valid_i`  in  1  result/opcode valid
- `result_ready_o`  out  1  block can accept a result (high only in IDLE)
- `tx_data_o`  out  8  byte to UART transmitter
- `tx_valid_o`  out  1  `tx_data_o` valid
- `tx_ready_i`  in  1  transmitter accepts the byte this cycle
- `busy_o`  out  1  packet in flight (state != IDLE)

## Operation
- Packet byte order: `opcode`, `0x00`, `LEN[7:0]`, `LEN[15:8]`, then `result` bytes LSB first, then checksum (if enabled).
- `LEN` = total packet bytes = 4 + RESULT_BYTES (+1 with checksum); 16-bit constant.
- Accept when `result_valid_i && result_ready_o`: register opcode and result; later changes on the inputs have no effect.
- FSM states:
  - IDLE: `result_ready_o`=1. On accept, go to HEADER with byte index 0.
  - HEADER: send header bytes 0..3. After byte 3 handshakes, go to PAYLOAD with index 0.
  - PAYLOAD: send `result[8*i +: 8]`. After byte RESULT_BYTES-1 handshakes, go to CSUM if enabled, otherwise IDLE.
  - CSUM: send the checksum byte. On handshake, go to IDLE.
- A byte completes only on `tx_valid_o && tx_ready_i`; the index advances only then.
- `tx_valid_o`=1 in every state except IDLE.
- `tx_data_o` is held stable while `tx_valid_o && !tx_ready_i`.
- `result_valid_i` asserted while busy: ignored (not accepted, not lost; the source holds it).

## Timing
- Reset values: `result_ready_o`=1 (the cycle after reset deasserts), `tx_valid_o`=0, `tx_data_o`=0x00, `busy_o`=0. Registered opcode, result, index and checksum are all cleared.
- Latency: accept in cycle N, first header byte is valid in cycle N+1.
- Throughput with `tx_ready_i` held high: one byte per cycle. Packet occupies 4+RESULT_BYTES(+1) cycles, then exactly one IDLE cycle before the next accept.
- No same-cycle accept on the last-byte handshake; `result_ready_o` rises the following cycle.
- `rst` mid-packet: the packet is aborted. The next cycle is IDLE with outputs at reset values; no partial resume.
- `tx_ready_i` high while `tx_valid_o`=0: no effect.

## Configuration
- `ALU_TX_CHECKSUM_EN` defined:
  - CSUM state present; a trailing byte equal to the XOR of all preceding packet bytes is sent.
  - `LEN` = 5 + RESULT_BYTES.
  - XOR accumulator is updated on each handshake and cleared on accept.
- Not defined:
  - No CSUM state and no accumulator.
  - `LEN` = 4 + RESULT_BYTES.

## Structure
- `config_pkg`:
  - opcode constants `OP_ECHO`=8'hEC, `OP_ADD`=8'hAD, `OP_MUL`=8'hAC, `OP_DIV`=8'hD1
  - `HDR_BYTES`=4
  - `tx_state_e` enum (IDLE, HEADER, PAYLOAD, CSUM)
- Sub-module `response_byte_select`: combinational mux from (state, index, registered opcode/result, LEN, checksum) to the outgoing byte. FSM, index counter and checksum register stay in the top module.

## Test plan
- RESULT_BYTES=4, no checksum, opcode 0xAD, result 0x00000007, `tx_ready_i`=1 -> bytes AD 00 08 00 07 00 00 00 on consecutive cycles starting N+1; `result_ready_o` high again at N+9.
- Same stimulus with `ALU_TX_CHECKSUM_EN` -> AD 00 09 00 07 00 00 00 A3.
- Back-pressure: drop `tx_ready_i` for 3 cycles while byte 2 (0x08) is presented -> `tx_data_o` holds 0x08 with `tx_valid_o`=1; stream resumes with 0x00, no byte dropped or duplicated.
- Opcode 0xEC, result 0xDEADBEEF, second `result_valid_i` asserted mid-packet -> first packet ends EF BE AD DE; second result accepted only after the IDLE cycle.
- Assert `rst` during payload byte 1 -> next cycle `tx_valid_o`=0, `busy_o`=0, `result_ready_o`=1. A new result 0x01 then produces a complete fresh packet.
- RESULT_BYTES=1, opcode 0xD1, result 0x05 -> D1 00 05 00 05.

Source files
------------

// File: rtl/config_pkg.sv
// Shared constants and types for the ALU response transmit path.
// ALU_TX_CHECKSUM_EN adds a trailing XOR checksum byte to each packet.
package config_pkg;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'hAC;
  localparam logic [7:0] OP_DIV  = 8'hD1;

  localparam int HDR_BYTES = 4;

`ifdef ALU_TX_CHECKSUM_EN
  localparam int CSUM_BYTES = 1;
`else
  localparam int CSUM_BYTES = 0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    CSUM
  } tx_state_e;

  function automatic logic [15:0] pkt_len(input int rb);
    return 16'(HDR_BYTES + rb + CSUM_BYTES);
  endfunction

endpackage

// File: rtl/response_byte_select.sv
// Picks the outgoing packet byte from FSM state, byte index and
// the registered opcode/result/length/checksum.
module response_byte_select
  import config_pkg::*;
#(
  parameter int RESULT_BYTES = 4
) (
  input  tx_state_e                 state,
  input  logic [3:0]                idx,
  input  logic [7:0]                opcode,
  input  logic [8*RESULT_BYTES-1:0] result,
  input  logic [15:0]               len,
  input  logic [7:0]                csum,
  output logic [7:0]                byte_o
);

  always_comb begin
    byte_o = 8'h00;
    unique case (state)
      HEADER: begin
        unique case (idx[1:0])
          2'd0:    byte_o = opcode;
          2'd1:    byte_o = 8'h00;
          2'd2:    byte_o = len[7:0];
          default: byte_o = len[15:8];
        endcase
      end
      PAYLOAD: begin
        for (int i = 0; i < RESULT_BYTES; i++) begin
          if (idx == 4'(i)) byte_o = result[8*i +: 8];
        end
      end
      CSUM:    byte_o = csum;
      default: byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/alu_response_tx.sv
// Frames one ALU result as a response packet and streams it bytewise.
// Build with ALU_TX_CHECKSUM_EN for a trailing XOR checksum byte.
module alu_response_tx
  import config_pkg::*;
#(
  parameter int RESULT_BYTES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                opcode_i,
  input  logic [8*RESULT_BYTES-1:0] result_i,
  input  logic                      result_valid_i,
  output logic                      result_ready_o,
  output logic [7:0]                tx_data_o,
  output logic                      tx_valid_o,
  input  logic                      tx_ready_i,
  output logic                      busy_o
);

  localparam logic [15:0] LEN = pkt_len(RESULT_BYTES);
  localparam logic [3:0] LAST_HDR = 4'(HDR_BYTES - 1);
  localparam logic [3:0] LAST_PL = 4'(RESULT_BYTES - 1);

`ifdef ALU_TX_CHECKSUM_EN
  localparam tx_state_e PL_NEXT = CSUM;
`else
  localparam tx_state_e PL_NEXT = IDLE;
`endif

  tx_state_e state, state_nx;
  logic [3:0] idx;
  logic [7:0] opcode_q;
  logic [8*RESULT_BYTES-1:0] result_q;
  logic [7:0] csum_q;
  logic accept;
  logic hs;

  assign accept = result_valid_i && result_ready_o;
  assign hs     = tx_valid_o && tx_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 4'd0;
      opcode_q <= 8'h00;
      result_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        opcode_q <= opcode_i;
        result_q <= result_i;
        idx      <= 4'd0;
      end else if (hs) begin
        // index restarts whenever the packet moves to its next section
        idx <= (state_nx != state) ? 4'd0 : idx + 4'd1;
      end
    end
  end

`ifdef ALU_TX_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || accept) csum_q <= 8'h00;
    else if (hs)       csum_q <= csum_q ^ tx_data_o;
  end
`else
  assign csum_q = 8'h00;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = HEADER;
      HEADER:  if (hs && idx == LAST_HDR) state_nx = PAYLOAD;
      PAYLOAD: if (hs && idx == LAST_PL) state_nx = PL_NEXT;
`ifdef ALU_TX_CHECKSUM_EN
      CSUM:    if (hs) state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    result_ready_o = 1'b0;
    tx_valid_o     = 1'b0;
    busy_o         = 1'b0;
    unique case (1'b1)
      (state == IDLE): result_ready_o = 1'b1;
      default: begin
        tx_valid_o = 1'b1;
        busy_o     = 1'b1;
      end
    endcase
  end

  response_byte_select #(
    .RESULT_BYTES(RESULT_BYTES)
  ) u_sel (
    .state (state),
    .idx   (idx),
    .opcode(opcode_q),
    .result(result_q),
    .len   (LEN),
    .csum  (csum_q),
    .byte_o(tx_data_o)
  );

endmodule

// File: tb/tb_alu_response_tx.sv
// Bench for alu_response_tx: vector table, corner sequences, random packets.
// Two instances: RESULT_BYTES=4 (a) and RESULT_BYTES=1 (b).
module tb_alu_response_tx;
  import config_pkg::*;

`ifdef ALU_TX_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  op_a, txd_a, op_b, txd_b;
  logic [31:0] res_a;
  logic [7:0]  res_b;
  logic val_a, rdy_a, txv_a, txr_a, busy_a;
  logic val_b, rdy_b, txv_b, txr_b, busy_b;

  alu_response_tx #(.RESULT_BYTES(4)) dut_a (
    .clk(clk), .rst(rst),
    .opcode_i(op_a), .result_i(res_a),
    .result_valid_i(val_a), .result_ready_o(rdy_a),
    .tx_data_o(txd_a), .tx_valid_o(txv_a),
    .tx_ready_i(txr_a), .busy_o(busy_a)
  );

  alu_response_tx #(.RESULT_BYTES(1)) dut_b (
    .clk(clk), .rst(rst),
    .opcode_i(op_b), .result_i(res_b),
    .result_valid_i(val_b), .result_ready_o(rdy_b),
    .tx_data_o(txd_b), .tx_valid_o(txv_b),
    .tx_ready_i(txr_b), .busy_o(busy_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // handshaken bytes and stall-stability checking
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic hold_a = 1'b0, hold_b = 1'b0;
  logic [7:0] hd_a, hd_b;

  always @(negedge clk) begin
    if (rst) begin
      hold_a = 1'b0;
      hold_b = 1'b0;
    end else begin
      if (txv_a && txr_a) q_a.push_back(txd_a);
      if (txv_b && txr_b) q_b.push_back(txd_b);
      if (hold_a) chk("hold_a", {txv_a, txd_a}, {1'b1, hd_a});
      if (hold_b) chk("hold_b", {txv_b, txd_b}, {1'b1, hd_b});
      hold_a = txv_a && !txr_a;
      hd_a   = txd_a;
      hold_b = txv_b && !txr_b;
      hd_b   = txd_b;
    end
  end

  logic rnd = 1'b0;
  always @(posedge clk) begin
    if (rnd) begin
      #1;
      txr_a = ($urandom_range(0, 3) != 0);
      txr_b = ($urandom_range(0, 3) != 0);
    end
  end

  // reference packet: header, little-endian payload, optional XOR
  logic [7:0] exp_q[$];
  function automatic void build(input logic [7:0] op,
                                input logic [31:0] res, input int rb);
    int len;
    logic [7:0] x;
    len = 4 + rb + CK;
    exp_q = {};
    exp_q.push_back(op);
    exp_q.push_back(8'h00);
    exp_q.push_back(len[7:0]);
    exp_q.push_back(len[15:8]);
    for (int i = 0; i < rb; i++) exp_q.push_back(res[8*i +: 8]);
    if (CK == 1) begin
      x = 8'h00;
      foreach (exp_q[i]) x ^= exp_q[i];
      exp_q.push_back(x);
    end
  endfunction

  function automatic logic [7:0] txd(input int s);
    return (s != 0) ? txd_b : txd_a;
  endfunction
  function automatic logic txv(input int s);
    return (s != 0) ? txv_b : txv_a;
  endfunction
  function automatic logic rdy(input int s);
    return (s != 0) ? rdy_b : rdy_a;
  endfunction
  function automatic logic busy(input int s);
    return (s != 0) ? busy_b : busy_a;
  endfunction

  // called at posedge+1; returns at posedge+1 right after acceptance
  task automatic send(input int s, input logic [7:0] op,
                      input logic [31:0] res);
    int n = 0;
    if (s != 0) begin
      op_b = op; res_b = res[7:0]; val_b = 1'b1;
    end else begin
      op_a = op; res_a = res; val_a = 1'b1;
    end
    @(negedge clk);
    while (!rdy(s) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 64'(n < 200), 64'd1);
    @(posedge clk);
    #1;
    // scramble inputs to show the packet uses latched values
    if (s != 0) begin
      val_b = 1'b0; op_b = 8'($urandom); res_b = 8'($urandom);
    end else begin
      val_a = 1'b0; op_a = 8'($urandom); res_a = $urandom;
    end
  endtask

  task automatic wait_idle(input int s);
    int n = 0;
    @(negedge clk);
    while (busy(s) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 64'(n < 500), 64'd1);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int               sel;
    logic [7:0]       op;
    logic [31:0]      res;
    int               n;
    logic [0:8][7:0]  exp;
  } vec_t;
  vec_t tbl[4];

  initial begin
`ifdef ALU_TX_CHECKSUM_EN
    tbl[0] = '{0, OP_ADD,  32'h00000007, 9, 72'hAD_00_09_00_07_00_00_00_A3};
    tbl[1] = '{0, OP_ECHO, 32'hDEADBEEF, 9, 72'hEC_00_09_00_EF_BE_AD_DE_C7};
    tbl[2] = '{0, OP_MUL,  32'h01020304, 9, 72'hAC_00_09_00_04_03_02_01_A1};
    tbl[3] = '{1, OP_DIV,  32'h00000005, 6, 72'hD1_00_06_00_05_D2_00_00_00};
`else
    tbl[0] = '{0, OP_ADD,  32'h00000007, 8, 72'hAD_00_08_00_07_00_00_00_00};
    tbl[1] = '{0, OP_ECHO, 32'hDEADBEEF, 8, 72'hEC_00_08_00_EF_BE_AD_DE_00};
    tbl[2] = '{0, OP_MUL,  32'h01020304, 8, 72'hAC_00_08_00_04_03_02_01_00};
    tbl[3] = '{1, OP_DIV,  32'h00000005, 5, 72'hD1_00_05_00_05_00_00_00_00};
`endif

    rst = 1'b1;
    op_a = 8'h00; res_a = 32'h0; val_a = 1'b0; txr_a = 1'b0;
    op_b = 8'h00; res_b = 8'h0;  val_b = 1'b0; txr_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_a", {rdy_a, txv_a, txd_a, busy_a}, {1'b1, 1'b0, 8'h00, 1'b0});
    chk("reset_b", {rdy_b, txv_b, txd_b, busy_b}, {1'b1, 1'b0, 8'h00, 1'b0});
    // ready with nothing valid must not start anything
    txr_a = 1'b1;
    txr_b = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_ready_a", {txv_a, busy_a}, 2'b00);
    @(posedge clk); #1;

    // vector table, tx_ready held high: one byte per cycle from N+1
    for (int v = 0; v < 4; v++) begin
      send(tbl[v].sel, tbl[v].op, tbl[v].res);
      for (int i = 0; i < tbl[v].n; i++) begin
        @(negedge clk);
        chk($sformatf("vec%0d_byte%0d", v, i),
            {txv(tbl[v].sel), rdy(tbl[v].sel), txd(tbl[v].sel)},
            {1'b1, 1'b0, tbl[v].exp[i]});
      end
      @(negedge clk);
      chk($sformatf("vec%0d_ready_after", v),
          {rdy(tbl[v].sel), txv(tbl[v].sel)}, 2'b10);
      @(posedge clk); #1;
    end

    // back-pressure on the length byte for 3 cycles
    q_a = {};
    build(OP_ADD, 32'h7, 4);
    send(0, OP_ADD, 32'h7);
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk); @(posedge clk); #1;
    txr_a = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_byte", {txv_a, txd_a}, {1'b1, exp_q[2]});
      @(posedge clk); #1;
    end
    txr_a = 1'b1;
    wait_idle(0);
    chk("stall_len", q_a.size(), exp_q.size());
    foreach (exp_q[i]) chk("stall_stream", q_a[i], exp_q[i]);

    // second result held valid during a packet
    build(OP_ECHO, 32'hDEADBEEF, 4);
    send(0, OP_ECHO, 32'hDEADBEEF);
    val_a = 1'b1; op_a = OP_ADD; res_a = 32'h1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      chk("busy_byte", {rdy_a, txd_a}, {1'b0, exp_q[i]});
    end
    @(negedge clk);
    chk("gap_idle", {rdy_a, txv_a}, 2'b10);
    @(negedge clk);
    chk("second_start", {txv_a, txd_a}, {1'b1, OP_ADD});
    @(posedge clk); #1;
    val_a = 1'b0;
    wait_idle(0);

    // reset during payload byte 1, then a fresh packet
    send(0, OP_ADD, 32'h7);
    repeat (5) begin
      @(negedge clk); @(posedge clk); #1;
    end
    chk("pre_abort", {txv_a, txd_a}, {1'b1, 8'h00});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort", {txv_a, busy_a, rdy_a, txd_a}, {1'b0, 1'b0, 1'b1, 8'h00});
    @(posedge clk); #1;
    q_a = {};
    build(OP_ADD, 32'h1, 4);
    send(0, OP_ADD, 32'h1);
    wait_idle(0);
    chk("fresh_len", q_a.size(), exp_q.size());
    foreach (exp_q[i]) chk("fresh_stream", q_a[i], exp_q[i]);

    // random packets under random back-pressure
    rnd = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [7:0] op;
      logic [31:0] res;
      int s;
      s = (k % 4 == 3) ? 1 : 0;
      op = 8'($urandom);
      res = $urandom;
      build(op, res, (s != 0) ? 1 : 4);
      q_a = {};
      q_b = {};
      send(s, op, res);
      wait_idle(s);
      if (s != 0) begin
        chk("rnd_len_b", q_b.size(), exp_q.size());
        foreach (exp_q[i]) chk("rnd_byte_b", q_b[i], exp_q[i]);
      end else begin
        chk("rnd_len_a", q_a.size(), exp_q.size());
        foreach (exp_q[i]) chk("rnd_byte_a", q_a[i], exp_q[i]);
      end
    end
    rnd = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
